// File: rtl/jk_monitor_pkg.sv
// Shared definitions for the JK flip-flop monitor: state encoding and the
// JK characteristic equation.
package jk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } mon_state_e;

  // Q after the next edge: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module jk_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/jk_monitor.sv
// Reader-side monitor for a JK flip-flop: waits for a run of well-formed
// q/qbar samples, then checks every edge against the JK characteristic.
module jk_monitor
  import jk_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SYNC_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             qbar,
  output logic             synced,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic             fail,
  output logic             exp_q
);

  localparam int RUN_W = (SYNC_CYC < 1) ? 1 : $clog2(SYNC_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_CYC - 1);

  mon_state_e       state_q;
  logic [RUN_W-1:0] run_q;
  logic             synced_q;
  logic             err_q;
  logic             fail_q;
  logic             pred_q;

  logic             in_check;
  logic             err_d;

  // Gated by en so an error seen on the edge where en falls is dropped.
  assign in_check = en && (state_q == ST_CHECK);
  assign err_d    = in_check && ((q != pred_q) || (q == qbar));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      synced_q <= 1'b0;
      err_q    <= 1'b0;
      fail_q   <= 1'b0;
      pred_q   <= 1'b0;
    end else if (!en) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      synced_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_SYNC;
          run_q   <= '0;
          err_q   <= 1'b0;
        end
        ST_SYNC: begin
          err_q <= 1'b0;
          if (q != qbar) begin
            run_q <= run_q + 1'b1;
            if (run_q == RUN_LAST) begin
              state_q  <= ST_CHECK;
              synced_q <= 1'b1;
              pred_q   <= jk_next(j, k, q);
            end
          end else begin
            run_q <= '0;
          end
        end
        ST_CHECK: begin
          // Predict from the sampled q, not the old prediction, so one bad
          // sample does not poison the following checks.
          err_q  <= err_d;
          pred_q <= jk_next(j, k, q);
          if (err_d) begin
            fail_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          synced_q <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  jk_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (err_d),
    .cnt   (err_cnt)
  );

  jk_sat_counter #(.CNT_W(CNT_W)) u_smp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (in_check),
    .cnt   (smp_cnt)
  );

  assign synced = synced_q;
  assign err    = err_q;
  assign fail   = fail_q;
  assign exp_q  = pred_q;

endmodule

// File: tb/tb_jk_monitor.sv
// Bench for jk_monitor: fixed vector table, corner-case sequences and a
// randomized run against a behavioural JK monitor model.
module tb_jk_monitor;

  localparam int SYNC_CYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, j = 1'b0, k = 1'b0, q = 1'b0, qbar = 1'b1;

  logic       synced, err, fail, exp_q;
  logic [7:0] err_cnt, smp_cnt;
  logic       synced_b, err_b, fail_b, exp_q_b;
  logic [1:0] err_cnt_b, smp_cnt_b;

  jk_monitor #(.CNT_W(8), .SYNC_CYC(SYNC_CYC)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .j(j), .k(k), .q(q), .qbar(qbar),
    .synced(synced), .err(err), .err_cnt(err_cnt), .smp_cnt(smp_cnt),
    .fail(fail), .exp_q(exp_q)
  );

  jk_monitor #(.CNT_W(2), .SYNC_CYC(SYNC_CYC)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .j(j), .k(k), .q(q), .qbar(qbar),
    .synced(synced_b), .err(err_b), .err_cnt(err_cnt_b), .smp_cnt(smp_cnt_b),
    .fail(fail_b), .exp_q(exp_q_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;

  // Behavioural model state
  logic m_active, m_synced, m_err, m_fail, m_pred;
  int   m_run, m_errs, m_smps;
  logic ff_q;

  typedef struct {
    logic [4:0] stim;   // {en, j, k, q, qbar}
    logic       synced;
    logic       err;
    int         err_cnt;
    int         smp_cnt;
    logic       fail;
    logic       exp_q;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [4:0] stim, input logic [1:0] se,
                              input int ec, input int sc, input logic [1:0] fx);
    vec_t v;
    v.stim = stim; v.synced = se[1]; v.err = se[0];
    v.err_cnt = ec; v.smp_cnt = sc; v.fail = fx[1]; v.exp_q = fx[0];
    return v;
  endfunction

  function automatic logic jk_ref(input logic jj, input logic kk, input logic qq);
    case ({jj, kk})
      2'b00:   return qq;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qq;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_synced = 1'b0; m_err = 1'b0; m_fail = 1'b0; m_pred = 1'b0;
    m_run = 0; m_errs = 0; m_smps = 0; ff_q = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic jj, input logic kk,
                            input logic qq, input logic qb);
    m_err = 1'b0;
    if (!e) begin
      m_active = 1'b0; m_run = 0; m_synced = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_run = 0;
    end else if (!m_synced) begin
      m_run = (qq != qb) ? m_run + 1 : 0;
      if (m_run == SYNC_CYC) begin
        m_synced = 1'b1;
        m_pred   = jk_ref(jj, kk, qq);
      end
    end else begin
      if ((qq != m_pred) || (qq == qb)) begin
        m_err = 1'b1; m_fail = 1'b1; m_errs++;
      end
      m_smps++;
      m_pred = jk_ref(jj, kk, qq);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".synced"},    32'(synced),    32'(m_synced));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(sat(m_errs, 255)));
    chk({tag, ".smp_cnt"},   32'(smp_cnt),   32'(sat(m_smps, 255)));
    chk({tag, ".fail"},      32'(fail),      32'(m_fail));
    chk({tag, ".exp_q"},     32'(exp_q),     32'(m_pred));
    chk({tag, ".err_cnt_w2"}, 32'(err_cnt_b), 32'(sat(m_errs, 3)));
  endtask

  // Called at a falling edge: drive, take one rising edge, return at the next falling edge.
  task automatic step(input logic e, input logic jj, input logic kk,
                      input logic qq, input logic qb);
    en = e; j = jj; k = kk; q = qq; qbar = qb;
    @(posedge clk);
    model_edge(e, jj, kk, qq, qb);
    ff_q = jk_ref(jj, kk, qq);
    @(negedge clk);
    if (err) err_pulses++;
    $display("[TB] t=%0t en=%b jk=%b%b q=%b qb=%b -> synced=%b err=%b err_cnt=%0d smp=%0d fail=%b exp_q=%b",
             $time, e, jj, kk, qq, qb, synced, err, err_cnt, smp_cnt, fail, exp_q);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0; qbar = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    int r;
    logic e, jj, kk, qq, qb;

    tbl[0]  = mk(5'b10001, 2'b00, 0, 0, 2'b00);
    tbl[1]  = mk(5'b10001, 2'b00, 0, 0, 2'b00);
    tbl[2]  = mk(5'b11001, 2'b10, 0, 0, 2'b01);
    tbl[3]  = mk(5'b11110, 2'b10, 0, 1, 2'b00);
    tbl[4]  = mk(5'b11101, 2'b10, 0, 2, 2'b01);
    tbl[5]  = mk(5'b10010, 2'b10, 0, 3, 2'b01);
    tbl[6]  = mk(5'b10110, 2'b10, 0, 4, 2'b00);
    tbl[7]  = mk(5'b10001, 2'b10, 0, 5, 2'b00);
    tbl[8]  = mk(5'b11001, 2'b10, 0, 6, 2'b01);
    tbl[9]  = mk(5'b10001, 2'b11, 1, 7, 2'b10);  // q stuck at 0 after set
    tbl[10] = mk(5'b10001, 2'b10, 1, 8, 2'b10);
    tbl[11] = mk(5'b00001, 2'b00, 1, 8, 2'b10);
    tbl[12] = mk(5'b10001, 2'b00, 1, 8, 2'b10);

    model_reset();
    #12;
    chk("rst.synced",  32'(synced),  32'd0);
    chk("rst.err",     32'(err),     32'd0);
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
    chk("rst.smp_cnt", 32'(smp_cnt), 32'd0);
    chk("rst.fail",    32'(fail),    32'd0);
    chk("rst.exp_q",   32'(exp_q),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: sync-up, correct JK sequence, stuck-q fault, en toggle
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].stim[4], tbl[i].stim[3], tbl[i].stim[2], tbl[i].stim[1], tbl[i].stim[0]);
      chk($sformatf("tbl%0d.synced", i),  32'(synced),  32'(tbl[i].synced));
      chk($sformatf("tbl%0d.err", i),     32'(err),     32'(tbl[i].err));
      chk($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].err_cnt));
      chk($sformatf("tbl%0d.smp_cnt", i), 32'(smp_cnt), 32'(tbl[i].smp_cnt));
      chk($sformatf("tbl%0d.fail", i),    32'(fail),    32'(tbl[i].fail));
      chk($sformatf("tbl%0d.exp_q", i),   32'(exp_q),   32'(tbl[i].exp_q));
    end

    // SYNC: q==qbar restarts the run and raises nothing
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("sync_eq.err", 32'(err), 32'd0);
    step(1, 0, 0, 0, 1);
    chk("sync_restart.synced", 32'(synced), 32'd0);
    step(1, 1, 0, 0, 1);
    chk("sync_done.synced", 32'(synced), 32'd1);
    check_model("sync");

    // CHECK: q==qbar alone, then both causes at once -> one pulse each
    p0 = err_pulses;
    step(1, 0, 0, 1, 1);
    chk("eq_only.err", 32'(err), 32'd1);
    step(1, 0, 0, 1, 0);
    chk("eq_only.pulses", 32'(err_pulses - p0), 32'd1);
    chk("eq_only.err_cnt", 32'(err_cnt), 32'd2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("both.pulses", 32'(err_pulses - p0), 32'd2);
    chk("both.err_cnt", 32'(err_cnt), 32'd3);
    check_model("both");

    // Saturation: 5 errors on a 2-bit counter
    do_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    p0 = err_pulses;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    chk("sat.pulses", 32'(err_pulses - p0), 32'd5);
    chk("sat.err_cnt_w2", 32'(err_cnt_b), 32'd3);
    chk("sat.err_cnt_w8", 32'(err_cnt), 32'd5);
    check_model("sat");

    // Asynchronous reset while an err pulse is on the output
    en = 1'b1; j = 1'b0; k = 1'b0; q = 1'b0; qbar = 1'b1;
    @(posedge clk);
    #2;
    chk("arst.pending_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.synced",     32'(synced),    32'd0);
    chk("arst.err",        32'(err),       32'd0);
    chk("arst.err_cnt",    32'(err_cnt),   32'd0);
    chk("arst.smp_cnt",    32'(smp_cnt),   32'd0);
    chk("arst.fail",       32'(fail),      32'd0);
    chk("arst.exp_q",      32'(exp_q),     32'd0);
    chk("arst.err_cnt_w2", 32'(err_cnt_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    p0 = err_pulses;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("arst.no_pulse", 32'(err_pulses - p0), 32'd0);
    check_model("arst");

    // Randomized JK traffic with occasional faults and en drops
    for (int i = 0; i < 300; i++) begin
      e  = ($urandom_range(0, 99) >= 3);
      jj = 1'($urandom_range(0, 1));
      kk = 1'($urandom_range(0, 1));
      qq = ff_q;
      qb = ~ff_q;
      r  = $urandom_range(0, 99);
      if (r < 6) begin
        qq = ~qq; qb = ~qq;
      end else if (r < 10) begin
        qb = qq;
      end
      step(e, jj, kk, qq, qb);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
